// File: rtl/ram_inferred_pl.sv
// Simple dual-port inferred RAM with byte-lane writes, registered read pipeline and a zero-fill sweep FSM.
// Optional macro RAM_INFERRED_PL_WR_BYPASS_EN forwards same-cycle write data to a colliding read.
module ram_inferred_pl #(
  parameter int ADDR           = 12,
  parameter int DATA           = 32,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR-1:0]   wr_addr,
  input  logic [DATA-1:0]   wr_data,
  input  logic [DATA/8-1:0] wr_be,
  input  logic              rd_en,
  input  logic [ADDR-1:0]   rd_addr,
  output logic [DATA-1:0]   rd_data,
  output logic              rd_valid,
  input  logic              clear_start,
  output logic              busy
);

  localparam int NB    = DATA / 8;
  localparam int DEPTH = 2 ** ADDR;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t          state_q;
  logic [ADDR-1:0] clr_addr_q;
  logic [DATA-1:0] mem_q [DEPTH];
  logic            wr_acc;
  logic            rd_acc;
  logic [DATA-1:0] rd_word_d;
  logic [DATA-1:0] rd_data_p0_q;
  logic            vld_p0_q;

  assign busy   = (state_q == CLEAR);
  assign wr_acc = wr_en & ~busy;
  assign rd_acc = rd_en & ~busy;

  // Clear sweep FSM; the address counter wraps to 0 on the last word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if (CLEAR_ON_RESET != 0) state_q <= CLEAR;
      else                     state_q <= IDLE;
      clr_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clear_start) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
          end
        end
        CLEAR: begin
          clr_addr_q <= clr_addr_q + 1'b1;
          if (clr_addr_q == {ADDR{1'b1}}) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == CLEAR) begin
        mem_q[clr_addr_q] <= '0;
      end else if (wr_acc) begin
        for (int i = 0; i < NB; i++) begin
          if (wr_be[i]) mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_word_d = mem_q[rd_addr];
`ifdef RAM_INFERRED_PL_WR_BYPASS_EN
    if (wr_acc && (wr_addr == rd_addr)) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) rd_word_d[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
`endif
  end

  // Stage p0: array read register; data only moves on an accepted read so it holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0_q     <= 1'b0;
      rd_data_p0_q <= '0;
    end else begin
      vld_p0_q <= rd_acc;
      if (rd_acc) rd_data_p0_q <= rd_word_d;
    end
  end

  // Stage p1: optional output register for RD_LAT=2.
  if (RD_LAT == 2) begin : g_lat2
    logic [DATA-1:0] rd_data_p1_q;
    logic            vld_p1_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_p1_q     <= 1'b0;
        rd_data_p1_q <= '0;
      end else begin
        vld_p1_q <= vld_p0_q;
        if (vld_p0_q) rd_data_p1_q <= rd_data_p0_q;
      end
    end

    assign rd_data  = rd_data_p1_q;
    assign rd_valid = vld_p1_q;
  end else begin : g_lat1
    assign rd_data  = rd_data_p0_q;
    assign rd_valid = vld_p0_q;
  end

endmodule

// File: doc/ram_inferred_pl.md
RAM_INFERRED_PL -- requirements
Module: ram_inferred_pl

Interface
REQ-001 SHALL have parameter ADDR, default 12, address width; depth = 2**ADDR words.
REQ-002 SHALL have parameter DATA, default 32, word width; must be a multiple of 8.
REQ-003 SHALL have parameter RD_LAT, default 1, read latency in cycles; legal values are 1 and 2.
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1; when 1, memory is zero-filled after reset.
REQ-005 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port wr_en  input  1  write request.
REQ-008 SHALL have port wr_addr  input  ADDR  write address.
REQ-009 SHALL have port wr_data  input  DATA  write data.
REQ-010 SHALL have port wr_be  input  DATA/8  byte-lane write enables; bit i controls wr_data[8i+7:8i].
REQ-011 SHALL have port rd_en  input  1  read request.
REQ-012 SHALL have port rd_addr  input  ADDR  read address.
REQ-013 SHALL have port rd_data  output  DATA  read data, registered.
REQ-014 SHALL have port rd_valid  output  1  rd_data valid strobe, high for exactly one cycle per accepted read.
REQ-015 SHALL have port clear_start  input  1  runtime zero-fill request.
REQ-016 SHALL have port busy  output  1  high while a clear sweep is in progress; accesses are ignored while high.

Function
REQ-017 SHALL be a simple dual-port RAM with one write port and one read port; storage SHALL be inferred block/huge RAM with no reset on the array.
REQ-018 SHALL, on a write, update only the byte lanes whose wr_be bit is 1 when wr_en=1 and busy=0; wr_be=0 leaves the word unchanged.
REQ-019 SHALL accept a read when rd_en=1 and busy=0 at edge N, and drive rd_data with rd_valid=1 after edge N+RD_LAT.
REQ-020 SHALL accept one read per cycle; back-to-back reads produce back-to-back rd_valid pulses.
REQ-021 SHALL hold rd_data at its last value while rd_valid=0.
REQ-022 SHALL use a 2-state FSM: IDLE and CLEAR.
REQ-023 SHALL transition IDLE->CLEAR on clear_start=1; clear_start SHALL be ignored in CLEAR.
REQ-024 SHALL, in CLEAR, write all-zero words to addresses 0..2**ADDR-1, one per cycle in ascending order, then return to IDLE; a sweep takes exactly 2**ADDR cycles.
REQ-025 SHALL drive busy=1 exactly while the FSM is in CLEAR.
REQ-026 SHALL ignore wr_en and rd_en while busy=1; no rd_valid pulse results from a read request made during CLEAR.
REQ-027 SHALL complete reads accepted before CLEAR entry, delivering rd_valid at N+RD_LAT with the pre-clear data.
REQ-028 SHALL wrap the clear address counter from 2**ADDR-1 to 0 on sweep completion; no extra cycle is added.
REQ-029 SHALL, on a same-cycle write and read to the same address without the bypass feature, return the old word (read-first).

Reset
REQ-030 SHALL, while rst_n=0, perform no array writes, set rd_data=0 and rd_valid=0, and flush the latency pipeline.
REQ-031 SHALL, while rst_n=0, set the FSM to CLEAR with clear address 0 if CLEAR_ON_RESET=1, otherwise to IDLE; busy resets to CLEAR_ON_RESET.
REQ-032 SHALL, on reset asserted mid-sweep, restart the sweep from address 0 (CLEAR_ON_RESET=1) or abort it (CLEAR_ON_RESET=0).
REQ-033 SHALL, when CLEAR_ON_RESET=1, write address 0 on the first edge with rst_n=1; busy SHALL fall 2**ADDR cycles after reset release.

Configuration
REQ-034 SHALL honour macro RAM_INFERRED_PL_WR_BYPASS_EN; when defined, a same-cycle accepted read and write to the same address SHALL return the new word: written lanes from wr_data, unwritten lanes from the old word.
REQ-035 SHALL, without RAM_INFERRED_PL_WR_BYPASS_EN, contain no forwarding logic and behave read-first per REQ-029.

Verification
REQ-036 SHALL be tested with ADDR=4, CLEAR_ON_RESET=1: release reset -> busy=1 for 16 cycles; read all 16 addresses -> all return 0.
REQ-037 SHALL be tested as follows: write 0xAABBCCDD to addr 3 with wr_be=0xF, then 0x11223344 with wr_be=0x5 -> read addr 3 returns 0xAA22CC44.
REQ-038 SHALL be tested with RD_LAT=2: rd_en on addrs 1,2,3 in consecutive cycles -> rd_valid high for 3 cycles, starting 2 cycles after the first request, with data in order.
REQ-039 SHALL be tested as follows: write 0x5 then a same-cycle write 0x9/read of addr 7 -> 0x5 without the macro; 0x9 with RAM_INFERRED_PL_WR_BYPASS_EN.
REQ-040 SHALL be tested as follows: clear_start pulse, then rd_en and wr_en during busy -> no rd_valid and no array change; after busy falls, all words read 0.
REQ-041 SHALL be tested as follows: rst_n=0 at sweep address 8 -> rd_valid=0; after release, the sweep restarts at 0 and busy lasts 16 full cycles.
